// File: rtl/rgb_uart_rx.sv
// rgb_uart_rx: 8-bit UART receiver that turns single-character commands
// into an RGB LED drive.
//
// Parameters
//   CLK_HZ  input clock frequency in Hz
//   BAUD    serial bit rate; CLKS_PER_BIT = CLK_HZ/BAUD must be at least 4
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   rx         asynchronous serial input, idle high
//   display    LED drive, [2]=R [1]=G [0]=B, 1 = on
//   valid      one-cycle pulse when a recognised command updates display
//   frame_err  one-cycle pulse on a bad stop bit (or bad parity bit)
//
// Optional feature
//   RGB_UART_RX_PARITY_EN  when defined, an even-parity bit follows data
//                          bit 7 and is checked before the stop bit.
//
// Command bytes: 'R' 100, 'G' 010, 'B' 001, 'W' 111, 'K' 000,
//                'Y' 110, 'C' 011, 'M' 101; all other bytes are ignored.

module rgb_uart_rx #(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [2:0] display,
  output logic       valid,
  output logic       frame_err
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef RGB_UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;

  state_t           state;
  logic             rx_meta;
  logic             rx_sync;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             decode_pend;
  logic             err_pend;
  logic [3:0]       dec;
`ifdef RGB_UART_RX_PARITY_EN
  logic             par_bad;
`endif

  // Returns {hit, rgb}; hit is low for bytes that are not commands.
  function automatic logic [3:0] decode(input logic [7:0] b);
    logic [3:0] r;
    r = 4'b0000;
    case (b)
      8'h52:   r = 4'b1100;  // R
      8'h47:   r = 4'b1010;  // G
      8'h42:   r = 4'b1001;  // B
      8'h57:   r = 4'b1111;  // W
      8'h4B:   r = 4'b1000;  // K
      8'h59:   r = 4'b1110;  // Y
      8'h43:   r = 4'b1011;  // C
      8'h4D:   r = 4'b1101;  // M
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  assign dec = decode(shift);

  // Two-flop synchroniser, preset high so reset looks like an idle line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      decode_pend <= 1'b0;
      err_pend    <= 1'b0;
      display     <= 3'b000;
      valid       <= 1'b0;
      frame_err   <= 1'b0;
`ifdef RGB_UART_RX_PARITY_EN
      par_bad     <= 1'b0;
`endif
    end else begin
      valid       <= 1'b0;
      frame_err   <= 1'b0;
      decode_pend <= 1'b0;
      err_pend    <= 1'b0;

      // Outputs are resolved one clock after the stop sample, from the
      // flags raised in STOP; the shift register is stable by then because
      // it only moves in DATA.
      if (decode_pend && dec[3]) begin
        display <= dec[2:0];
        valid   <= 1'b1;
      end
      if (err_pend) begin
        frame_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (!rx_sync) begin
            state <= START;
            cnt   <= '0;
          end
        end

        START: begin
          // Re-check at mid-bit so short glitches do not start a frame.
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_sync ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            shift   <= {rx_sync, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef RGB_UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

`ifdef RGB_UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            // Even parity: data ones plus the parity bit must be even.
            par_bad <= ^{shift, rx_sync};
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif

        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_sync) begin
              state <= IDLE;
`ifdef RGB_UART_RX_PARITY_EN
              if (par_bad) begin
                err_pend <= 1'b1;
              end else begin
                decode_pend <= 1'b1;
              end
`else
              decode_pend <= 1'b1;
`endif
            end else begin
              // Line held low: wait for it to go idle so the low level is
              // not mistaken for a new start bit.
              err_pend <= 1'b1;
              state    <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WAIT_IDLE: begin
          if (rx_sync) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_uart_rx.sv
// tb_rgb_uart_rx: self-checking bench for rgb_uart_rx at CLK_HZ=1 MHz,
// BAUD=100 kHz (10 clocks per bit). A scoreboard of expected output events
// is filled as frames are sent and checked against the DUT every cycle.

module tb_rgb_uart_rx;

  localparam int CPB = 10;
`ifdef RGB_UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int NB = PAR_EN ? 9 : 8;
  // Start-edge to output-pulse delay: synchroniser (2), edge detect (1),
  // mid-start check (CPB/2+1), data and parity bits, stop bit, decode (1).
  localparam int LAT = 2 + 1 + (CPB / 2 + 1) + NB * CPB + CPB + 1;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx    = 1'b1;
  logic [2:0] display;
  logic       valid;
  logic       frame_err;

  longint cyc = 0;
  int     n_cmp = 0;
  int     n_bad = 0;
  bit     armed = 1'b0;

  typedef struct {
    longint     at;
    bit         v;
    logic [2:0] col;
  } ev_t;

  ev_t        evq[$];
  logic [2:0] exp_disp = 3'b000;
  int         n_valid = 0;
  int         n_ferr  = 0;
  longint     vld_at[$];
  logic [2:0] colour [int];

  rgb_uart_rx #(
    .CLK_HZ(1000000),
    .BAUD  (100000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .display  (display),
    .valid    (valid),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30)
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the scoreboard.
  always @(negedge clk) begin
    bit ev_v;
    bit ev_fe;
    if (armed) begin
      ev_v  = 1'b0;
      ev_fe = 1'b0;
      if (!rst_n) begin
        exp_disp = 3'b000;
        evq.delete();
      end else if (evq.size() > 0 && evq[0].at == cyc) begin
        if (evq[0].v) begin
          ev_v     = 1'b1;
          exp_disp = evq[0].col;
        end else begin
          ev_fe = 1'b1;
        end
        evq.delete(0);
      end
      check("valid", 64'(valid), 64'(ev_v));
      check("frame_err", 64'(frame_err), 64'(ev_fe));
      check("display", 64'(display), 64'(exp_disp));
      if (valid === 1'b1) begin
        n_valid++;
        vld_at.push_back(cyc);
      end
      if (frame_err === 1'b1) n_ferr++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    idle(CPB);
  endtask

  // Sends one frame starting now; records the expected output event.
  task automatic send(input logic [7:0] d, input bit stop_val = 1'b1,
                      input bit par_flip = 1'b0, input int hold_low = 0);
    ev_t e;
    bit  pbad;
    e.at  = cyc + LAT;
    e.v   = 1'b0;
    e.col = 3'b000;
    pbad  = par_flip && PAR_EN;
    if (!stop_val || pbad) begin
      evq.push_back(e);
    end else if (colour.exists(int'(d))) begin
      e.v   = 1'b1;
      e.col = colour[int'(d)];
      evq.push_back(e);
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit((^d) ^ par_flip);
    drive_bit(stop_val);
    if (!stop_val) idle(hold_low);
    rx = 1'b1;
  endtask

  // Starts an 'R' frame and pulses reset during data bit 4.
  task automatic send_reset_mid(input logic [7:0] d);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = 1'b1;
    idle(3);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(150);
  endtask

  initial begin
    longint     t0;
    logic [7:0] cols [3];
    logic [2:0] cexp [3];
    colour[32'h52] = 3'b100;
    colour[32'h47] = 3'b010;
    colour[32'h42] = 3'b001;
    colour[32'h57] = 3'b111;
    colour[32'h4B] = 3'b000;
    colour[32'h59] = 3'b110;
    colour[32'h43] = 3'b011;
    colour[32'h4D] = 3'b101;

    #3 rst_n = 1'b0;
    armed = 1'b1;
    idle(4);
    rst_n = 1'b1;
    idle(5);
    check("reset display", 64'(display), 64'(3'b000));

    // 'R' and its latency
    t0 = cyc;
    send(8'h52);
    idle(20);
    check("R display", 64'(display), 64'(3'b100));
    check("R valid count", 64'(n_valid), 64'(1));
    check("R latency", 64'(vld_at[0] - t0), PAR_EN ? 64'(110) : 64'(100));

    // 'W' then 'K' back-to-back
    send(8'h57);
    send(8'h4B);
    idle(20);
    check("WK display", 64'(display), 64'(3'b000));
    check("WK valid count", 64'(n_valid), 64'(3));
    check("WK spacing", 64'(vld_at[2] - vld_at[1]), PAR_EN ? 64'(110) : 64'(100));

    // 'G' then an unknown byte
    send(8'h47);
    idle(5);
    send(8'h41);
    idle(20);
    check("G41 display", 64'(display), 64'(3'b010));
    check("G41 valid count", 64'(n_valid), 64'(4));
    check("G41 ferr count", 64'(n_ferr), 64'(0));

    // 'B' with a low stop bit, line held low, then a good 'B'
    send(8'h42, 1'b0, 1'b0, 50);
    idle(20);
    check("badstop ferr count", 64'(n_ferr), 64'(1));
    check("badstop display", 64'(display), 64'(3'b010));
    send(8'h42);
    idle(20);
    check("B display", 64'(display), 64'(3'b001));
    check("B valid count", 64'(n_valid), 64'(5));

    // 3-clock glitch on the idle line
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(40);
    check("glitch valid count", 64'(n_valid), 64'(5));
    check("glitch ferr count", 64'(n_ferr), 64'(1));

    // Reset during bit 4 of 'R'
    send_reset_mid(8'h52);
    check("midreset display", 64'(display), 64'(3'b000));
    check("midreset valid count", 64'(n_valid), 64'(5));

    // Reception resumes; repeated command pulses valid again
    send(8'h52);
    send(8'h52);
    idle(20);
    check("RR display", 64'(display), 64'(3'b100));
    check("RR valid count", 64'(n_valid), 64'(7));

    // Remaining colours
    cols[0] = 8'h59; cexp[0] = 3'b110;
    cols[1] = 8'h43; cexp[1] = 3'b011;
    cols[2] = 8'h4D; cexp[2] = 3'b101;
    for (int i = 0; i < 3; i++) begin
      send(cols[i]);
      idle(10);
      check("colour display", 64'(display), 64'(cexp[i]));
    end

`ifdef RGB_UART_RX_PARITY_EN
    send(8'h43, 1'b1, 1'b1);
    idle(20);
    check("badpar ferr count", 64'(n_ferr), 64'(2));
    check("badpar display", 64'(display), 64'(3'b101));
    send(8'h43);
    idle(20);
    check("goodpar display", 64'(display), 64'(3'b011));
    check("goodpar valid count", 64'(n_valid), 64'(11));
`endif

    idle(5);
    check("scoreboard drained", 64'(evq.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rgb_uart_rx.md
RGB_UART_RX -- requirements
Module: rgb_uart_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, meaning the input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, meaning the serial bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division), at least 4.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-006 SHALL have port display, output, 3 bits: the LED colour drive; [2]=R, [1]=G, [0]=B, 1 = on.
REQ-007 SHALL have port valid, output, 1 bit: one-cycle pulse when a recognised command updates display.
REQ-008 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit (or a bad parity bit when enabled).

Function
REQ-009 SHALL pass rx through a 2-flop synchroniser (preset to 1) before any use; all references to rx below mean the synchronised value.
REQ-010 SHALL implement the FSM IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, plus a WAIT_IDLE state.
REQ-011 IDLE: a low rx SHALL enter START and clear the baud counter.
REQ-012 START: at count CLKS_PER_BIT/2, rx low -> DATA with counter cleared; rx high -> IDLE (glitch rejected, no outputs).
REQ-013 DATA: SHALL sample rx every CLKS_PER_BIT clocks, 8 bits, LSB first, into a shift register; after bit 7 -> PARITY (if enabled) else STOP.
REQ-014 STOP: SHALL sample rx after CLKS_PER_BIT clocks; high -> decode and go to IDLE; low -> pulse frame_err, display unchanged, go to WAIT_IDLE.
REQ-015 WAIT_IDLE: SHALL remain until rx is high, then go to IDLE.
REQ-016 Decode table: 0x52 'R' -> 100, 0x47 'G' -> 010, 0x42 'B' -> 001, 0x57 'W' -> 111, 0x4B 'K' -> 000, 0x59 'Y' -> 110, 0x43 'C' -> 011, 0x4D 'M' -> 101.
REQ-017 Any other byte with a good stop bit SHALL be ignored: display holds, no valid, no frame_err.
REQ-018 For a recognised byte, display SHALL update and valid SHALL pulse high in the same cycle, exactly 1 clock after the stop-bit sample.
REQ-019 display SHALL hold its value indefinitely between commands; repeating the same command still pulses valid.
REQ-020 A new start bit SHALL be accepted from the cycle after the return to IDLE, so back-to-back frames with a 1-bit stop are received without loss.
REQ-021 valid and frame_err SHALL never be high in the same cycle.

Reset
REQ-022 rst_n low SHALL asynchronously force state = IDLE, counters = 0, shift register = 0, display = 3'b000, valid = 0, frame_err = 0, synchroniser flops = 1.
REQ-023 Reset asserted mid-frame SHALL abandon the frame with no output pulse; reception restarts at the next start bit after release.

Configuration
REQ-024 Macro RGB_UART_RX_PARITY_EN SHALL control the parity bit.
REQ-025 Macro defined: an even-parity bit follows data bit 7, sampled in PARITY; a mismatch pulses frame_err after the stop bit (1 clock after the stop sample), display unchanged, then IDLE or WAIT_IDLE as per the stop bit.
REQ-026 Macro undefined: there is no PARITY state and frames are 10 bits (start, 8 data, stop).

Verification (CLK_HZ=1000000, BAUD=100000, CLKS_PER_BIT=10)
REQ-027 Reset then send 0x52 -> display=100, valid high for 1 clock, 1 clock after the stop sample, frame_err=0.
REQ-028 Send 0x57 then 0x4B back-to-back -> display=111 then 000, two valid pulses 100 clocks apart.
REQ-029 Send 0x41 after 'G' -> display stays 010, no valid, no frame_err.
REQ-030 Send 0x42 with the stop bit forced low -> frame_err pulse, display unchanged; holding rx low 50 clocks keeps FSM in WAIT_IDLE; after rx returns high, 'B' gives display=001.
REQ-031 A 3-clock low glitch on idle rx -> no pulses, FSM returns to IDLE; rst_n pulsed during bit 4 of 'R' -> display=000, no valid.
REQ-032 With RGB_UART_RX_PARITY_EN defined, 'C' (0x43) with a wrong parity bit -> frame_err, display unchanged; with correct parity -> display=011, valid.
